// File: rtl/xor_cipher_rx.sv
// Receive side of the serial XOR cipher: loads a serial key, deserializes a
// ciphertext frame and presents the recovered plaintext with a valid pulse.
module xor_cipher_rx #(
  parameter int unsigned KEY_SIZE = 4,
  parameter int unsigned MSG_SIZE = 8
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iData_in,
  input  logic                iLoad_key,
  input  logic                iValid,
  output logic [MSG_SIZE-1:0] oPlain,
  output logic                oPlain_valid,
  output logic                oKey_ready,
  output logic                oBusy,
  output logic                oFrame_err
);

  localparam int unsigned CNT_W = $clog2(MSG_SIZE + 1);
  localparam int unsigned REP   = MSG_SIZE / KEY_SIZE;
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SIZE);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_SIZE);

  if ((MSG_SIZE % KEY_SIZE) != 0) begin : g_bad_size
    $error("xor_cipher_rx: MSG_SIZE must be an integer multiple of KEY_SIZE");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    RECV     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MSG_SIZE-1:0] shift_q, shift_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [MSG_SIZE-1:0] plain_q, plain_d;
  logic                plain_valid_q, plain_valid_d;
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic                err_lock_q, err_lock_d;

  logic [MSG_SIZE-1:0] shift_in_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic [MSG_SIZE-1:0] akey_c;

  // Shared deserializer: the key only uses the low KEY_SIZE bits.
  assign shift_in_c = MSG_SIZE'({shift_q, iData_in});
  assign cnt_inc_c  = cnt_q + CNT_W'(1);
  assign akey_c     = {REP{key_q}};

  always_ff @(posedge clk) begin
    if (!iRst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      key_q         <= '0;
      plain_q       <= '0;
      plain_valid_q <= 1'b0;
      key_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      err_lock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      key_q         <= key_d;
      plain_q       <= plain_d;
      plain_valid_q <= plain_valid_d;
      key_ready_q   <= key_ready_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      err_lock_q    <= err_lock_d;
    end
  end

  // Next-state logic; with iEn low everything, pulses included, holds.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    key_d         = key_q;
    plain_d       = plain_q;
    plain_valid_d = plain_valid_q;
    key_ready_d   = key_ready_q;
    frame_err_d   = frame_err_q;
    err_lock_d    = err_lock_q;

    if (iEn) begin
      plain_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      if (!iValid) begin
        err_lock_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (iLoad_key) begin
            key_ready_d = 1'b0;
            shift_d     = shift_in_c;
            cnt_d       = cnt_inc_c;
            state_d     = LOAD_KEY;
            if (cnt_inc_c == KEY_LAST) begin
              key_d       = shift_in_c[KEY_SIZE-1:0];
              key_ready_d = 1'b1;
              cnt_d       = '0;
              state_d     = IDLE;
            end
          end else if (iValid) begin
            if (key_ready_q) begin
              shift_d = shift_in_c;
              cnt_d   = cnt_inc_c;
              state_d = RECV;
              if (cnt_inc_c == MSG_LAST) begin
                plain_d       = shift_in_c ^ akey_c;
                plain_valid_d = 1'b1;
                cnt_d         = '0;
                state_d       = IDLE;
              end
            end else if (!err_lock_q) begin
              // One error per unkeyed iValid burst.
              frame_err_d = 1'b1;
              err_lock_d  = 1'b1;
            end
          end
        end

        LOAD_KEY: begin
          cnt_d   = '0;
          state_d = IDLE;
          if (iLoad_key) begin
            shift_d = shift_in_c;
            if (cnt_inc_c == KEY_LAST) begin
              key_d       = shift_in_c[KEY_SIZE-1:0];
              key_ready_d = 1'b1;
            end else begin
              cnt_d   = cnt_inc_c;
              state_d = LOAD_KEY;
            end
          end
        end

        RECV: begin
          cnt_d   = '0;
          state_d = IDLE;
          if (iValid) begin
            shift_d = shift_in_c;
            if (cnt_inc_c == MSG_LAST) begin
              plain_d       = shift_in_c ^ akey_c;
              plain_valid_d = 1'b1;
            end else begin
              cnt_d   = cnt_inc_c;
              state_d = RECV;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign oPlain       = plain_q;
  assign oPlain_valid = plain_valid_q;
  assign oKey_ready   = key_ready_q;
  assign oBusy        = busy_q;
  assign oFrame_err   = frame_err_q;

endmodule

// File: tb/tb_xor_cipher_rx.sv
// Directed self-checking bench for xor_cipher_rx (KEY_SIZE=4, MSG_SIZE=8).
module tb_xor_cipher_rx;

  localparam int unsigned KEY_SIZE = 4;
  localparam int unsigned MSG_SIZE = 8;

  logic                clk = 1'b0;
  logic                iRst;
  logic                iEn;
  logic                iData_in;
  logic                iLoad_key;
  logic                iValid;
  logic [MSG_SIZE-1:0] oPlain;
  logic                oPlain_valid;
  logic                oKey_ready;
  logic                oBusy;
  logic                oFrame_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xor_cipher_rx #(.KEY_SIZE(KEY_SIZE), .MSG_SIZE(MSG_SIZE)) dut (
    .clk          (clk),
    .iRst         (iRst),
    .iEn          (iEn),
    .iData_in     (iData_in),
    .iLoad_key    (iLoad_key),
    .iValid       (iValid),
    .oPlain       (oPlain),
    .oPlain_valid (oPlain_valid),
    .oKey_ready   (oKey_ready),
    .oBusy        (oBusy),
    .oFrame_err   (oFrame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [KEY_SIZE-1:0] k);
    iLoad_key = 1'b1;
    for (int i = KEY_SIZE - 1; i >= 0; i--) begin
      iData_in = k[i];
      tick();
    end
    iLoad_key = 1'b0;
    iData_in  = 1'b0;
    check("key_ready", 32'(oKey_ready), 32'd1);
    check("key_busy_clear", 32'(oBusy), 32'd0);
  endtask

  // Leaves iValid high so a following call runs back to back.
  task automatic send_frame(input logic [MSG_SIZE-1:0] c, input logic [MSG_SIZE-1:0] exp, input string tag);
    int early;
    early  = 0;
    iValid = 1'b1;
    for (int i = MSG_SIZE - 1; i >= 0; i--) begin
      iData_in = c[i];
      tick();
      if (i > 0) early += int'(oPlain_valid) + int'(oFrame_err);
    end
    check({tag, "_early_pulse"}, 32'(early), 32'd0);
    check({tag, "_plain"}, 32'(oPlain), 32'(exp));
    check({tag, "_valid"}, 32'(oPlain_valid), 32'd1);
    check({tag, "_err"}, 32'(oFrame_err), 32'd0);
  endtask

  initial begin
    iRst = 1'b0; iEn = 1'b1; iData_in = 1'b0; iLoad_key = 1'b0; iValid = 1'b0;
    tick();
    tick();
    check("rst_plain", 32'(oPlain), 32'd0);
    check("rst_valid", 32'(oPlain_valid), 32'd0);
    check("rst_key_ready", 32'(oKey_ready), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_err", 32'(oFrame_err), 32'd0);
    iRst = 1'b1;

    // Frame before any key: one error for the whole iValid burst.
    iValid = 1'b1; iData_in = 1'b1;
    tick();
    check("nokey_err", 32'(oFrame_err), 32'd1);
    check("nokey_key_ready", 32'(oKey_ready), 32'd0);
    check("nokey_valid", 32'(oPlain_valid), 32'd0);
    check("nokey_busy", 32'(oBusy), 32'd0);
    tick();
    check("nokey_err_lock1", 32'(oFrame_err), 32'd0);
    tick();
    check("nokey_err_lock2", 32'(oFrame_err), 32'd0);
    iValid = 1'b0;
    tick();
    check("nokey_err_end", 32'(oFrame_err), 32'd0);

    // iLoad_key wins over iValid; early drop discards the partial key.
    iLoad_key = 1'b1; iValid = 1'b1; iData_in = 1'b1;
    tick();
    check("prio_err", 32'(oFrame_err), 32'd0);
    check("prio_busy", 32'(oBusy), 32'd1);
    iValid = 1'b0;
    tick();
    iLoad_key = 1'b0;
    tick();
    check("early_drop_busy", 32'(oBusy), 32'd0);
    check("early_drop_key_ready", 32'(oKey_ready), 32'd0);
    check("early_drop_err", 32'(oFrame_err), 32'd0);

    // Key 1010, frame 6C -> C6.
    load_key(4'b1010);
    send_frame(8'h6C, 8'hC6, "f6c");
    iValid = 1'b0;
    tick();
    check("f6c_valid_one_cycle", 32'(oPlain_valid), 32'd0);
    check("f6c_hold_plain", 32'(oPlain), 32'hC6);

    // Key 5, frame 69 with a 3-cycle iEn stall after bit 4 -> 3C.
    load_key(4'h5);
    iValid = 1'b1;
    for (int i = 7; i >= 4; i--) begin
      iData_in = 8'h69 >> i;
      tick();
    end
    iEn = 1'b0; iValid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      iData_in = s[0];
      tick();
      check("stall_busy", 32'(oBusy), 32'd1);
      check("stall_plain", 32'(oPlain), 32'hC6);
      check("stall_valid", 32'(oPlain_valid), 32'd0);
      check("stall_err", 32'(oFrame_err), 32'd0);
    end
    iEn = 1'b1; iValid = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      iData_in = 8'h69 >> i;
      tick();
    end
    check("stall_final_plain", 32'(oPlain), 32'h3C);
    check("stall_final_valid", 32'(oPlain_valid), 32'd1);
    // A pending pulse holds while iEn is low.
    iEn = 1'b0; iValid = 1'b0;
    tick();
    tick();
    check("pulse_hold_valid", 32'(oPlain_valid), 32'd1);
    iEn = 1'b1;
    tick();
    check("pulse_release_valid", 32'(oPlain_valid), 32'd0);

    // Round trip: encryptor(key 5, msg 3C) produced 69.
    send_frame(8'h69, 8'h3C, "roundtrip");

    // Abort after 5 bits.
    for (int i = 7; i >= 3; i--) begin
      iData_in = 8'h12 >> i;
      tick();
      check("abort_no_err_yet", 32'(oFrame_err), 32'd0);
    end
    iValid = 1'b0;
    tick();
    check("abort_err", 32'(oFrame_err), 32'd1);
    check("abort_valid", 32'(oPlain_valid), 32'd0);
    check("abort_plain", 32'(oPlain), 32'h3C);
    check("abort_busy", 32'(oBusy), 32'd0);
    tick();
    check("abort_err_one_cycle", 32'(oFrame_err), 32'd0);

    // Back-to-back frames with key A.
    load_key(4'hA);
    send_frame(8'h00, 8'hAA, "b2b0");
    send_frame(8'hFF, 8'h55, "b2b1");
    iValid = 1'b0;
    tick();

    // Reset in the middle of a frame.
    iValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iData_in = 1'b1;
      tick();
    end
    check("midrst_busy_before", 32'(oBusy), 32'd1);
    iRst = 1'b0;
    tick();
    check("midrst_plain", 32'(oPlain), 32'd0);
    check("midrst_valid", 32'(oPlain_valid), 32'd0);
    check("midrst_key_ready", 32'(oKey_ready), 32'd0);
    check("midrst_busy", 32'(oBusy), 32'd0);
    check("midrst_err", 32'(oFrame_err), 32'd0);
    iRst = 1'b1;
    tick();
    check("postrst_err", 32'(oFrame_err), 32'd1);
    check("postrst_key_ready", 32'(oKey_ready), 32'd0);
    iValid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_cipher_rx.md
# xor_cipher_rx

Receive-side counterpart of the serial XOR cipher encryptor. Loads a serial KEY_SIZE-bit key and replicates it to MSG_SIZE bits, then deserializes a ciphertext frame framed by the encryptor's done flag. It XORs the frame with the assembled key and presents the recovered plaintext in parallel with a one-cycle valid pulse. It sits on the link side, clocked by the same slow clock that drives the encryptor's serial output.

## Interface
- KEY_SIZE, 4, key width in bits; MSG_SIZE must be an integer multiple of KEY_SIZE (elaboration error otherwise)
- MSG_SIZE, 8, ciphertext/plaintext width in bits
- clk  in  1  single clock; all state updates on rising edge
- iRst  in  1  reset, synchronous, active-low
- iEn  in  1  global enable; when low, all state and outputs hold and no bit is sampled
- iData_in  in  1  serial data, key bits and ciphertext bits, MSB first
- iLoad_key  in  1  high while key bits are presented
- iValid  in  1  ciphertext framing: high for exactly MSG_SIZE enabled cycles per frame
- oPlain  out  MSG_SIZE  recovered plaintext, held until next frame completes
- oPlain_valid  out  1  one-cycle pulse when oPlain updates
- oKey_ready  out  1  a complete key is loaded
- oBusy  out  1  FSM not in IDLE
- oFrame_err  out  1  one-cycle pulse on an aborted or unkeyed frame

## Operation
- FSM states: IDLE, LOAD_KEY, RECV. A bit counter of width clog2(MSG_SIZE+1) is shared by key and frame reception.
- A "sampling cycle" is a rising edge with iRst=1 and iEn=1. With iEn=0, nothing changes, including pulses: a pending pulse is held until iEn returns.
- IDLE, iLoad_key=1:
  - Capture the first key bit, clear oKey_ready, go to LOAD_KEY.
  - iLoad_key has priority over iValid in the same cycle; iValid is ignored and no error is raised.
- IDLE, iValid=1, oKey_ready=1: capture the first ciphertext bit, go to RECV.
- IDLE, iValid=1, oKey_ready=0: pulse oFrame_err. Stay in IDLE and ignore the bit. Raise no further errors until iValid has been low for at least one sampling cycle.
- LOAD_KEY:
  - Shift in one bit per sampling cycle while iLoad_key=1.
  - On the KEY_SIZE-th bit: commit the key and form the assembled key by replicating the key MSG_SIZE/KEY_SIZE times (key 4'hA gives 8'hAA). Set oKey_ready and return to IDLE.
  - If iLoad_key drops early: discard the partial key, leave oKey_ready=0, return to IDLE, and raise no error.
- RECV:
  - Shift in one bit per sampling cycle while iValid=1. iLoad_key is ignored.
  - On the MSG_SIZE-th bit: oPlain <= {shift,bit} ^ assembled key, pulse oPlain_valid, return to IDLE.
  - If iValid drops before MSG_SIZE bits: pulse oFrame_err, discard the partial frame, leave oPlain unchanged, return to IDLE.
- The assembled key persists across frames until the next complete key load.

## Timing
- Reset (synchronous, iRst=0 at an edge):
  - Outputs: oPlain=0, oPlain_valid=0, oKey_ready=0, oBusy=0, oFrame_err=0.
  - Internal state: key=0, counter=0, FSM=IDLE.
  - Reset mid-frame or mid-key-load discards everything.
- Key ready: oKey_ready rises on the edge that samples the last key bit. A frame may start on the next sampling cycle.
- Plaintext latency: oPlain and oPlain_valid update on the edge that samples the last ciphertext bit. They are visible for the following cycle; the valid pulse lasts exactly one cycle.
- Back-to-back frames: if iValid stays high after the last bit, the next sampling cycle is bit 7 (MSB) of a new frame. There is no gap cycle.
- The error pulse is asserted on the edge that detects the abort and lasts one cycle.
- oBusy is high in LOAD_KEY and RECV, including across iEn=0 stalls.

## Test plan
- Key 4'b1010, then frame 8'h6C -> oPlain=8'hC6, single-cycle oPlain_valid on the edge of the 8th bit, oFrame_err stays 0.
- Round trip: encryptor with key 4'h5 and message 8'h3C produces 8'h69; feeding its output and done flag to this block -> oPlain=8'h3C.
- iEn low for 3 cycles after bit 4 of frame 8'h69 (key 4'h5) -> no state change during the stall, final oPlain=8'h3C.
- iValid drops after 5 bits -> oFrame_err pulses once, no oPlain_valid, oPlain retains its previous value, FSM returns to IDLE.
- iValid before any key load -> oFrame_err pulses once, oKey_ready=0, no oPlain_valid.
- Two back-to-back frames 8'h00 and 8'hFF (key 4'hA) -> oPlain 8'hAA then 8'h55, valid pulses 8 cycles apart.
- iRst=0 mid-frame -> all outputs 0 on that edge, oKey_ready=0; a subsequent frame raises oFrame_err.
